// File: rtl/tx_serializer_if.sv
// tx_serializer_if: encoder-side word input and serial-side outputs of the TX serializer
interface tx_serializer_if #(
  parameter int WIDTH  = 10,
  parameter int UCNT_W = 8
);
  logic [WIDTH-1:0]  TxParallel_10;
  logic              TxValid;
  logic              BitCLK_10;
  logic              WordLoad;
  logic              TxSerial;
  logic [UCNT_W-1:0] UnderrunCnt;
  modport master (
    output TxParallel_10, TxValid,
    input  BitCLK_10, WordLoad, TxSerial, UnderrunCnt
  );
  modport slave (
    input  TxParallel_10, TxValid,
    output BitCLK_10, WordLoad, TxSerial, UnderrunCnt
  );
endinterface

// File: rtl/tx_serializer.sv
// tx_serializer: loads one code group per WIDTH bit clocks, shifts it out, inserts idle on underrun
module tx_serializer #(
  parameter int               WIDTH     = 10,
  parameter bit               MSB_FIRST = 1'b0,
  parameter logic [WIDTH-1:0] IDLE_WORD = 10'b0011111010,
  parameter int               UCNT_W    = 8
) (
  input logic           BitCLK,
  input logic           Reset,
  tx_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  if (WIDTH < 4 || WIDTH % 2 != 0) begin : g_bad_width
    $error("tx_serializer: WIDTH must be even and >= 4");
  end
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [WIDTH-1:0]  shreg, shreg_nxt, word;
  logic [UCNT_W-1:0] ucnt;
  logic              load, bit_nxt, ser, wclk, wload;
  always_comb begin
    load      = cnt == CW'(WIDTH - 1);
    cnt_nxt   = load ? '0 : cnt + 1'b1;
    word      = bus.TxValid ? bus.TxParallel_10 : IDLE_WORD;
    shreg_nxt = load ? word : (MSB_FIRST ? shreg << 1 : shreg >> 1);
    bit_nxt   = MSB_FIRST ? shreg_nxt[WIDTH-1] : shreg_nxt[0];
  end
  // The output bit is taken from the post-shift value so a new word appears with no gap
  always_ff @(posedge BitCLK or negedge Reset) begin
    if (!Reset) begin
      cnt   <= CW'(WIDTH - 1);
      shreg <= '0;
      ser   <= 1'b0;
      wclk  <= 1'b0;
      wload <= 1'b0;
      ucnt  <= '0;
    end else begin
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
      ser   <= bit_nxt;
      wclk  <= cnt_nxt < CW'(WIDTH / 2);
      wload <= load;
      if (load && !bus.TxValid && !(&ucnt)) ucnt <= ucnt + 1'b1;
    end
  end
  assign bus.TxSerial    = ser;
  assign bus.BitCLK_10   = wclk;
  assign bus.WordLoad    = wload;
  assign bus.UnderrunCnt = ucnt;
endmodule

// File: tb/tb_tx_serializer.sv
// tb_tx_serializer: directed checks of LSB-first and MSB-first serializer instances
module tb_tx_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  tx_serializer_if #(.WIDTH(10), .UCNT_W(8)) a ();
  tx_serializer_if #(.WIDTH(10), .UCNT_W(8)) b ();
  tx_serializer #(.WIDTH(10), .MSB_FIRST(1'b0), .IDLE_WORD(10'b0011111010), .UCNT_W(8)) dut_lsb (
    .BitCLK(clk), .Reset(rst_n), .bus(a.slave)
  );
  tx_serializer #(.WIDTH(10), .MSB_FIRST(1'b1), .IDLE_WORD(10'b0011111010), .UCNT_W(8)) dut_msb (
    .BitCLK(clk), .Reset(rst_n), .bus(b.slave)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic restart(input logic [9:0] da, input logic va, input logic [9:0] db, input logic vb);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    a.TxParallel_10 = da;
    a.TxValid = va;
    b.TxParallel_10 = db;
    b.TxValid = vb;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({a.TxSerial, a.BitCLK_10, a.WordLoad, a.UnderrunCnt} !== 11'd0) begin
        errors++;
        $display("FAIL reset_lsb: got ser=%b wclk=%b wl=%b ucnt=%0d, want all 0", a.TxSerial, a.BitCLK_10, a.WordLoad, a.UnderrunCnt);
      end
      checks++;
      if ({b.TxSerial, b.BitCLK_10, b.WordLoad, b.UnderrunCnt} !== 11'd0) begin
        errors++;
        $display("FAIL reset_msb: got ser=%b wclk=%b wl=%b ucnt=%0d, want all 0", b.TxSerial, b.BitCLK_10, b.WordLoad, b.UnderrunCnt);
      end
      tick();
    end
  endtask
  task automatic test_lsb_first();
    logic [9:0] w = 10'b1010110001;
    restart(w, 1'b1, 10'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (a.TxSerial !== w[i] || a.BitCLK_10 !== (i < 5) || a.WordLoad !== (i == 0)) begin
        errors++;
        $display("FAIL lsb_first edge %0d: got ser=%b wclk=%b wl=%b, want ser=%b wclk=%b wl=%b", i + 1, a.TxSerial, a.BitCLK_10, a.WordLoad, w[i], i < 5, i == 0);
      end
    end
  endtask
  task automatic test_back_to_back();
    restart(10'h3FF, 1'b1, 10'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (a.TxSerial !== (i < 10) || a.WordLoad !== (i % 10 == 0)) begin
        errors++;
        $display("FAIL back_to_back edge %0d: got ser=%b wl=%b, want ser=%b wl=%b", i + 1, a.TxSerial, a.WordLoad, i < 10, i % 10 == 0);
      end
      if (i == 0) a.TxParallel_10 = 10'h000;
      if (i == 3) a.TxValid = 1'b0;
      if (i == 7) a.TxValid = 1'b1;
    end
    checks++;
    if (a.UnderrunCnt !== 8'd0) begin
      errors++;
      $display("FAIL back_to_back_ucnt: got %0d, want 0", a.UnderrunCnt);
    end
  endtask
  task automatic test_underrun();
    logic [9:0] idle = 10'b0011111010;
    restart(10'h155, 1'b0, 10'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i < 10) begin
        checks++;
        if (a.TxSerial !== idle[i]) begin
          errors++;
          $display("FAIL underrun_bit %0d: got %b, want %b", i, a.TxSerial, idle[i]);
        end
      end
      if (i == 0 || i == 19) begin
        checks++;
        if (a.UnderrunCnt !== 8'd1) begin
          errors++;
          $display("FAIL underrun_cnt edge %0d: got %0d, want 1", i + 1, a.UnderrunCnt);
        end
      end
      if (i == 0) a.TxValid = 1'b1;
    end
  endtask
  task automatic test_saturate();
    restart(10'h0F0, 1'b0, 10'd0, 1'b1);
    for (int t = 1; t <= 3000; t++) begin
      tick();
      if (t == 2521 || t == 2531 || t == 2541 || t == 3000) begin
        int want;
        want = (t == 2521) ? 253 : (t == 2531) ? 254 : 255;
        checks++;
        if (a.UnderrunCnt !== 8'(want)) begin
          errors++;
          $display("FAIL saturate t=%0d: got %0d, want %0d", t, a.UnderrunCnt, want);
        end
      end
    end
  endtask
  task automatic test_reset_mid_word();
    restart(10'h3FF, 1'b1, 10'd0, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (a.TxSerial !== 1'b1 || a.BitCLK_10 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got ser=%b wclk=%b, want 1 1", a.TxSerial, a.BitCLK_10);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a.TxSerial, a.BitCLK_10, a.WordLoad, a.UnderrunCnt} !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset_async: got ser=%b wclk=%b wl=%b ucnt=%0d, want all 0", a.TxSerial, a.BitCLK_10, a.WordLoad, a.UnderrunCnt);
    end
    a.TxParallel_10 = 10'h000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (a.TxSerial !== 1'b0 || a.WordLoad !== (i == 0) || a.BitCLK_10 !== (i < 5)) begin
        errors++;
        $display("FAIL after_reset edge %0d: got ser=%b wl=%b wclk=%b, want ser=0 wl=%b wclk=%b", i + 1, a.TxSerial, a.WordLoad, a.BitCLK_10, i == 0, i < 5);
      end
    end
  endtask
  task automatic test_msb_first();
    logic [9:0] w = 10'b1100000001;
    restart(10'd0, 1'b1, w, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (b.TxSerial !== w[9 - (i % 10)] || b.BitCLK_10 !== (i % 10 < 5)) begin
        errors++;
        $display("FAIL msb_first edge %0d: got ser=%b wclk=%b, want ser=%b wclk=%b", i + 1, b.TxSerial, b.BitCLK_10, w[9 - (i % 10)], i % 10 < 5);
      end
    end
  endtask
  initial begin
    a.TxParallel_10 = '0;
    a.TxValid = 1'b1;
    b.TxParallel_10 = '0;
    b.TxValid = 1'b1;
    test_reset();
    test_lsb_first();
    test_back_to_back();
    test_underrun();
    test_saturate();
    test_reset_mid_word();
    test_msb_first();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
